// File: rtl/reg_file32_pkg.sv
// Shared definitions for the single-cycle datapath register file and its neighbours.
// Holds the default widths, the hardwired-zero register index, the clear-sequencer
// state encoding and the ALU32 control codes so every block and bench agrees on them.
package reg_file32_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned AddrWDefault = 5;

  // Index of the register that always reads zero.
  localparam int unsigned RegZero = 0;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } rf_state_e;

  typedef enum logic [2:0] {
    AluAnd = 3'd0,
    AluOr  = 3'd1,
    AluAdd = 3'd2,
    AluSub = 3'd6,
    AluSlt = 3'd7
  } alu_ctl_e;

endpackage

// File: rtl/reg_clear_seq.sv
// Post-reset clear sequencer for reg_file32.
// After reset it walks clr_addr_o from 0 to NREG-1, one entry per cycle, asking the
// register file to zero each entry; then it enters RUN and raises ready_o.
// Ports:
//   clk_i       rising-edge clock
//   reset_i     synchronous active-high reset; restarts the sweep from entry 0
//   clr_we_o    1 = zero the entry at clr_addr_o on this edge
//   clr_addr_o  entry being cleared
//   ready_o     1 = sweep finished, register file usable
module reg_clear_seq
  import reg_file32_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LastIdx = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: the counter wraps back to 0 as the sweep ends and then stays idle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastIdx) begin
          state_d = StRun;
        end
      end
      StRun: begin
        clr_cnt_d = clr_cnt_q;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // Outputs: no clearing while reset is held, so the sweep starts on the first low edge.
  always_comb begin
    clr_we_o   = (state_q == StClear) && !reset_i;
    clr_addr_o = clr_cnt_q;
    ready_o    = (state_q == StRun);
  end

endmodule

// File: rtl/reg_file32.sv
// Integer register file of the single-cycle datapath, feeding ALU32 operands a/b.
// Register 0 reads as zero. After reset every entry is zeroed one per cycle; ready_o
// stays low (and both read ports return 0) until that sweep is finished.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle core write to a
// matching read port (write-through); without it a same-cycle read sees the old value.
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset
//   reg_write_i    write enable from main control
//   read_reg1_i    rs index
//   read_reg2_i    rt index
//   write_reg_i    destination index
//   write_data_i   write value (ALU result / load data)
//   read_data1_o   operand A to ALU32
//   read_data2_o   operand B to ALU32 (before the ALUSrc mux)
//   ready_o        1 = clear sweep finished
module reg_file32
  import reg_file32_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] read_reg1_i,
  input  logic [ADDR_W-1:0] read_reg2_i,
  input  logic [ADDR_W-1:0] write_reg_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic [DATA_W-1:0] read_data1_o,
  output logic [DATA_W-1:0] read_data2_o,
  output logic              ready_o
);

  localparam int unsigned       NReg    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(RegZero);

  logic [DATA_W-1:0] mem_q [NReg];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              core_we;

  reg_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .ready_o   (ready)
  );

  // Core writes only land in RUN and never touch the hardwired-zero entry.
  assign core_we = ready && !reset_i && reg_write_i && (write_reg_i != ZeroIdx);

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (core_we) begin
      mem_q[write_reg_i] <= write_data_i;
    end
  end

  always_comb begin
    read_data1_o = '0;
    if (ready && (read_reg1_i != ZeroIdx)) begin
      read_data1_o = mem_q[read_reg1_i];
`ifdef REGFILE_BYPASS_EN
      if (core_we && (write_reg_i == read_reg1_i)) begin
        read_data1_o = write_data_i;
      end
`endif
    end
  end

  always_comb begin
    read_data2_o = '0;
    if (ready && (read_reg2_i != ZeroIdx)) begin
      read_data2_o = mem_q[read_reg2_i];
`ifdef REGFILE_BYPASS_EN
      if (core_we && (write_reg_i == read_reg2_i)) begin
        read_data2_o = write_data_i;
      end
`endif
    end
  end

  assign ready_o = ready;

endmodule
